// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the RAM load/store initiator: access-size
// encodings, FSM state encoding, the latched load context and the
// alignment check used by both the datapath and the control.
package ram_lsu_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_RSP  = 2'b10;

  // Load shaping information captured at accept; the CPU may change
  // req_* immediately after the handshake.
  typedef struct packed {
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } ld_ctx_t;

  // 1 when the access is misaligned for its size or the size is illegal
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = |off;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ram_lsu_master_if.sv
// CPU request/response and RAM bus signals of the load/store initiator.
// master = the initiator itself, slave = CPU + RAM environment.
interface ram_lsu_master_if #(
  parameter int AW = 13
);

  // CPU request
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;

  // CPU response
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  // RAM port
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_sel;
  logic [31:0]   ram_di;
  logic          ram_we;
  logic [31:0]   ram_doq;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output ram_addr, ram_sel, ram_di, ram_we,
    input  ram_doq
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  ram_addr, ram_sel, ram_di, ram_we,
    output ram_doq
  );

endinterface

// File: rtl/ram_lsu_align.sv
// Combinational lane logic for the big-endian RAM: byte selects and
// lane-replicated store data for the live request, and extraction plus
// sign/zero extension of load data using the latched load context.
// Byte offset 0 is the most significant lane (sel[3], data[31:24]).
module ram_lsu_align
  import ram_lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_doq,
  output logic [3:0]  o_sel,
  output logic [31:0] o_di,
  output logic        o_err,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  // Byte selects, replicated write data and access check for the live request
  always_comb begin
    o_sel = 4'b0000;
    o_di  = 32'h0000_0000;
    o_err = access_err(i_st_size, i_st_off);
    case (i_st_size)
      SZ_BYTE: begin
        o_sel = 4'b1000 >> i_st_off;
        o_di  = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_sel = i_st_off[1] ? 4'b0011 : 4'b1100;
        o_di  = {2{i_st_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_sel = 4'b1111;
        o_di  = i_st_wdata;
      end
      default: begin
        o_sel = 4'b0000;
        o_di  = 32'h0000_0000;
      end
    endcase
  end

  // Select the addressed byte and half-word lanes of the read word
  always_comb begin
    w_ld_byte = 8'h00;
    case (i_ld_off)
      2'd0:    w_ld_byte = i_ld_doq[31:24];
      2'd1:    w_ld_byte = i_ld_doq[23:16];
      2'd2:    w_ld_byte = i_ld_doq[15:8];
      default: w_ld_byte = i_ld_doq[7:0];
    endcase
    if (i_ld_off[1]) begin
      w_ld_half = i_ld_doq[15:0];
    end else begin
      w_ld_half = i_ld_doq[31:16];
    end
  end

  // Right-justify and extend the selected lane to 32 bits
  always_comb begin
    o_ld_data = 32'h0000_0000;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: o_ld_data = {{16{i_ld_signed & w_ld_half[15]}}, w_ld_half};
      SZ_WORD: o_ld_data = i_ld_doq;
      default: o_ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ram_lsu_master.sv
// Load/store initiator for a synchronous single-port data RAM with
// byte-select writes and a registered read address. One request in flight:
// stores and rejected accesses respond one cycle after accept, loads two
// cycles after accept (one RAM read-latency cycle in RD). The RAM lines are
// driven combinationally from the live request; only the accept cycle may
// write.
module ram_lsu_master
  import ram_lsu_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic             clk,
  input  logic             rst,
  ram_lsu_master_if.master bus
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  ld_ctx_t     r_ld;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_err;
  logic [3:0]  w_sel;
  logic [31:0] w_di;
  logic [31:0] w_ld_data;

  assign w_accept = bus.req_valid & (r_state == ST_IDLE);

  ram_lsu_align u_align (
    .i_st_size   (bus.req_size),
    .i_st_off    (bus.req_addr[1:0]),
    .i_st_wdata  (bus.req_wdata),
    .i_ld_size   (r_ld.size),
    .i_ld_off    (r_ld.off),
    .i_ld_signed (r_ld.sgn),
    .i_ld_doq    (bus.ram_doq),
    .o_sel       (w_sel),
    .o_di        (w_di),
    .o_err       (w_err),
    .o_ld_data   (w_ld_data)
  );

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.ram_addr  = bus.req_addr[AW+1:2];
  assign bus.ram_sel   = w_sel;
  assign bus.ram_di    = w_di;
  assign bus.ram_we    = w_accept & bus.req_we & ~w_err;
  assign bus.rsp_valid = (r_state == ST_RSP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // Next-state decode: clean loads wait a read cycle, everything else responds next
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err | bus.req_we) begin
            w_state_nxt = ST_RSP;
          end else begin
            w_state_nxt = ST_RD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RSP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture load shaping info at accept so later req_* changes cannot corrupt it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld <= '0;
    end else if (w_accept) begin
      r_ld <= '{size: bus.req_size, sgn: bus.req_signed, off: bus.req_addr[1:0]};
    end else begin
      r_ld <= r_ld;
    end
  end

  // Response payload: zero for stores/errors, shaped RAM data for loads, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= w_err;
          end
        end
        ST_RD: begin
          r_rdata <= w_ld_data;
          r_err   <= 1'b0;
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_rdata <= 32'h0000_0000;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu_master.sv
// Self-checking bench for ram_lsu_master: directed cases followed by random
// traffic, checked against a byte-addressed big-endian memory model and
// plain rules for selects, lane data, error detection and response timing.
module tb_ram_lsu_master;
  import ram_lsu_pkg::*;

  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_lsu_master_if #(.AW(AW)) bus ();

  ram_lsu_master #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM: registered read address, byte-select write
  logic [31:0] ram_q [0:(1<<AW)-1];
  always @(posedge clk) begin
    bus.ram_doq <= ram_q[bus.ram_addr];
    if (bus.ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_sel[i]) ram_q[bus.ram_addr][8*i +: 8] <= bus.ram_di[8*i +: 8];
      end
    end
  end

  // Reference: flat byte memory, offset 0 holds the most significant byte
  logic [7:0] ref_mem [0:(1<<(AW+2))-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Throw junk onto the request lines while the DUT is busy
  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    bus.req_valid  = r[0];
    bus.req_we     = r[1];
    bus.req_size   = r[3:2];
    bus.req_signed = r[4];
    r = $urandom;
    bus.req_addr   = r[AW+1:0];
    bus.req_wdata  = $urandom;
  endtask

  task automatic busy_checks(input string tag);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.ram_we), 32'd0);
  endtask

  // One complete transaction, checked end to end
  task automatic run_op(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [AW+1:0] addr, input logic [31:0] wd,
                        input int hold, input bit rst_in_rd, output logic [31:0] got_rd);
    int n, off, base, a;
    logic err;
    logic [3:0] exp_sel;
    logic [31:0] exp_di, exp_rd, t, mask;
    off = int'(addr[1:0]);
    a = int'(addr);
    n = (sz == 2'd3) ? 0 : (1 << sz);
    err = (n == 0) || ((a % n) != 0);
    exp_sel = 4'b0000;
    base = (sz == 2'd1) ? (off & 2) : ((sz == 2'd2) ? 0 : off);
    for (int i = 0; i < n; i++) exp_sel[3 - (base + i)] = 1'b1;
    exp_di = (n == 1) ? (32'(wd[7:0]) * 32'h0101_0101) :
             (n == 2) ? (32'(wd[15:0]) * 32'h0001_0001) : wd;
    exp_rd = 32'h0;
    if (!we && !err) begin
      for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[a + i]);
      if (n < 4) begin
        mask = (32'h1 << (8 * n)) - 32'h1;
        if (sgn && exp_rd[8*n-1]) exp_rd = exp_rd | ~mask;
      end
    end
    got_rd = 32'h0;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wd;
    bus.rsp_ready = 1'b0;
    #1;
    chk("acc_ready", 32'(bus.req_ready), 32'd1);
    chk("acc_sel", 32'(bus.ram_sel), 32'(exp_sel));
    chk("acc_addr", 32'(bus.ram_addr), 32'(addr[AW+1:2]));
    chk("acc_we", 32'(bus.ram_we), 32'(we && !err));
    if (we && !err) chk("acc_di", bus.ram_di, exp_di);
    @(posedge clk);
    if (we && !err) begin
      for (int i = 0; i < n; i++) begin
        t = wd >> (8 * (n - 1 - i));
        ref_mem[a + i] = t[7:0];
      end
    end
    @(negedge clk);
    if (!we && !err) begin
      if (rst_in_rd) begin
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rd_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("postrst_ready", 32'(bus.req_ready), 32'd1);
        return;
      end
      scramble();
      #1 chk("rd_valid", 32'(bus.rsp_valid), 32'd0);
      busy_checks("rd");
      @(negedge clk);
    end
    scramble();
    busy_checks("rsp");
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(err));
    got_rd = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble();
      busy_checks("hold");
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(err));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, r;
    logic [AW+1:0] ad;
    for (int i = 0; i < (1 << AW); i++) ram_q[i] = 32'h0;
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_we", 32'(bus.ram_we), 32'd0);
    rst = 1'b0;

    // Word store then load
    run_op(1'b1, SZ_WORD, 1'b0, 15'h0010, 32'h1122_3344, 0, 1'b0, rd);
    run_op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 0, 1'b0, rd);
    chk("word_const", rd, 32'h1122_3344);
    // Byte path
    run_op(1'b1, SZ_BYTE, 1'b0, 15'h0013, 32'h0000_00AB, 0, 1'b0, rd);
    run_op(1'b0, SZ_BYTE, 1'b1, 15'h0013, 32'h0, 0, 1'b0, rd);
    chk("byte_s_const", rd, 32'hFFFF_FFAB);
    run_op(1'b0, SZ_BYTE, 1'b0, 15'h0013, 32'h0, 0, 1'b0, rd);
    chk("byte_u_const", rd, 32'h0000_00AB);
    // Half path
    run_op(1'b1, SZ_HALF, 1'b0, 15'h0020, 32'h0000_8001, 0, 1'b0, rd);
    run_op(1'b0, SZ_HALF, 1'b1, 15'h0020, 32'h0, 0, 1'b0, rd);
    chk("half_s_const", rd, 32'hFFFF_8001);
    run_op(1'b0, SZ_WORD, 1'b0, 15'h0020, 32'h0, 0, 1'b0, rd);
    chk("half_word_hi", {16'h0, rd[31:16]}, 32'h0000_8001);
    // Error cases
    run_op(1'b1, SZ_HALF, 1'b0, 15'h0021, 32'hDEAD_BEEF, 0, 1'b0, rd);
    run_op(1'b1, SZ_WORD, 1'b0, 15'h0022, 32'hDEAD_BEEF, 0, 1'b0, rd);
    run_op(1'b1, SZ_ILL, 1'b0, 15'h0020, 32'hDEAD_BEEF, 0, 1'b0, rd);
    run_op(1'b0, SZ_WORD, 1'b0, 15'h0020, 32'h0, 0, 1'b0, rd);
    chk("err_nowrite", rd, 32'h8001_0000);
    // Backpressure and reset during the read cycle
    run_op(1'b0, SZ_WORD, 1'b0, 15'h0010, 32'h0, 5, 1'b0, rd);
    run_op(1'b0, SZ_HALF, 1'b0, 15'h0012, 32'h0, 0, 1'b1, rd);
    run_op(1'b0, SZ_BYTE, 1'b0, 15'h0011, 32'h0, 0, 1'b0, rd);
    chk("after_rst_const", rd, 32'h0000_0022);

    // Random traffic, mostly in a small window so loads hit earlier stores
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      if (r[1:0] == 2'b00) ad = r[AW+1+8:8];
      else ad = 15'(r[13:8]);
      run_op(r[2], r[4:3], r[5], ad, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 49) == 0), rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
